// File: rtl/alu_iter.sv
// Execute-stage ALU with registered result, valid/ready handshake and
// iterative unsigned shift-add multiply / restoring divide units.
`timescale 1ns/1ps
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SRL   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opnd_q;
  logic [SHW:0]         cnt_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     hi_q;
  logic                 ovf_q;
  logic                 div0_q;

  logic                 accept_s;
  logic [WIDTH-1:0]     sum_s;
  logic [WIDTH-1:0]     diff_s;
  logic [WIDTH-1:0]     alu_res_s;
  logic                 alu_ovf_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       div_part_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   acc_d;
  logic [SHW:0]         cnt_d;

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign dataOut   = data_q;
  assign hi        = hi_q;
  assign zero      = (data_q == '0);
  assign overflow  = ovf_q;
  assign div0      = div0_q;

  // Single-cycle result and signed-overflow flag from the live operands
  always_comb begin
    sum_s     = dataA + dataB;
    diff_s    = dataA - dataB;
    alu_res_s = '0;
    alu_ovf_s = 1'b0;
    case (Signal)
      OP_AND:  alu_res_s = dataA & dataB;
      OP_OR:   alu_res_s = dataA | dataB;
      OP_ADD: begin
        alu_res_s = sum_s;
        alu_ovf_s = (dataA[WIDTH-1] == dataB[WIDTH-1]) && (sum_s[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = diff_s;
        alu_ovf_s = (dataA[WIDTH-1] != dataB[WIDTH-1]) && (diff_s[WIDTH-1] != dataA[WIDTH-1]);
      end
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
      OP_SRL:  alu_res_s = dataB >> shamt;
      OP_SLL:  alu_res_s = dataB << shamt;
      OP_SRA:  alu_res_s = $unsigned($signed(dataB) >>> shamt);
      default: alu_res_s = '0;
    endcase
  end

  // One multiply or divide iteration; acc holds {high/remainder, low/quotient}
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_part_s  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial_s = div_part_s - {1'b0, opnd_q};
    cnt_d       = cnt_q - {{SHW{1'b0}}, 1'b1};
    if (state_q == S_MUL) begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (!div_trial_s[WIDTH]) begin
      acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {div_part_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with registered result, flags and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      hi_q        <= '0;
      ovf_q       <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            case (Signal)
              OP_MULTU: begin
                acc_q   <= {{WIDTH{1'b0}}, dataB};
                opnd_q  <= dataA;
                cnt_q   <= CNT_INIT;
                state_q <= S_MUL;
              end
              OP_DIVU: begin
                if (dataB == '0) begin
                  data_q      <= '1;
                  hi_q        <= dataA;
                  ovf_q       <= 1'b0;
                  div0_q      <= 1'b1;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
                end else begin
                  acc_q   <= {{WIDTH{1'b0}}, dataA};
                  opnd_q  <= dataB;
                  cnt_q   <= CNT_INIT;
                  state_q <= S_DIV;
                end
              end
              default: begin
                data_q      <= alu_res_s;
                hi_q        <= '0;
                ovf_q       <= alu_ovf_s;
                div0_q      <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              data_q      <= acc_d[WIDTH-1:0];
              hi_q        <= acc_d[2*WIDTH-1:WIDTH];
              ovf_q       <= 1'b0;
              div0_q      <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= state_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
